// File: rtl/seq_divider_n_bit_pkg.sv
// Shared constants for the sequential divider: FSM state encoding.
`ifndef SEQ_DIVIDER_N_BIT_PKG_SV
`define SEQ_DIVIDER_N_BIT_PKG_SV

package seq_divider_n_bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold the value n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`endif

// File: rtl/seq_divider_n_bit_subtractor.sv
// Combinational trial subtractor: diff = a - b, borrow set when b > a.
module subtractor_n_bit #(
    parameter int w = 5
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] diff,
    output logic         borrow
);

    // Extend by one bit so the borrow appears as the top bit of the result.
    always_comb begin
        {borrow, diff} = {1'b0, a} - {1'b0, b};
    end

endmodule

// File: rtl/seq_divider_n_bit.sv
// Restoring sequential divider: one quotient bit per clock, MSB first.
module seq_divider_n_bit
    import seq_divider_n_bit_pkg::*;
#(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [size-1:0] in_a,
    input  logic [size-1:0] in_b,
    output logic [size-1:0] out_q,
    output logic [size-1:0] out_r,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero
);

    localparam int unsigned CW = cnt_width(size);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom,
    // so after the last step this register holds the quotient.
    logic [size-1:0] quo_q, quo_d;
    logic [size-1:0] rem_q, rem_d;
    logic [size-1:0] dsr_q, dsr_d;
    logic            dbz_q, dbz_d;

    logic [size:0]   shifted;
    logic [size:0]   diff;
    logic            borrow;
    // A kept difference is always below the divisor, so its top bit is zero.
    logic            diff_msb_unused;

    assign shifted         = {rem_q, quo_q[size-1]};
    assign diff_msb_unused = diff[size];

    subtractor_n_bit #(
        .w(size + 1)
    ) u_sub (
        .a      (shifted),
        .b      ({1'b0, dsr_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    // Next-state logic: operand capture, restoring steps and completion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dsr_d = in_b;
                    cnt_d = CW'(size);
                    dbz_d = (in_b == '0);
                    if (in_b == '0) begin
                        quo_d   = '1;
                        rem_d   = in_a;
                        state_d = DONE;
                    end else begin
                        quo_d   = in_a;
                        rem_d   = '0;
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = borrow ? shifted[size-1:0] : diff[size-1:0];
                quo_d = {quo_q[size-2:0], ~borrow};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign out_q       = quo_q;
    assign out_r       = rem_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_n_bit.sv
// Directed bench for seq_divider_n_bit with a scoreboard of expected results.
module tb_seq_divider_n_bit;

    localparam int SIZE = 4;

    typedef struct {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE-1:0] q;
        logic [SIZE-1:0] r;
        logic            dbz;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [SIZE-1:0] in_a = '0;
    logic [SIZE-1:0] in_b = '0;
    logic [SIZE-1:0] out_q;
    logic [SIZE-1:0] out_r;
    logic            busy;
    logic            done;
    logic            div_by_zero;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    seq_divider_n_bit #(
        .size(SIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_q       (out_q),
        .out_r       (out_r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q   = {SIZE{1'b1}};
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = SIZE'(int'(a) / int'(b));
            e.r   = SIZE'(int'(a) % int'(b));
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drive an accepted start, record the expectation, then scramble the operands.
    task automatic launch(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        sb.push_back(model(a, b));
        tick();
        start = 1'b0;
        in_a  = SIZE'($urandom);
        in_b  = SIZE'($urandom);
    endtask

    // Wait (bounded) for done; exp_extra is the number of further edges expected.
    task automatic wait_done(input int exp_extra);
        int   k = 0;
        exp_t e;
        while (done !== 1'b1 && k < 20) begin
            check("busy_run", busy, 1);
            tick();
            k++;
        end
        check("latency", k, exp_extra);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (done === 1'b1) begin
                check("out_q", out_q, e.q);
                check("out_r", out_r, e.r);
                check("div_by_zero", div_by_zero, e.dbz);
                check("busy_done", busy, 0);
                if (e.b != 0) begin
                    check("identity", 32'(out_q) * 32'(e.b) + 32'(out_r), e.a);
                    check("rem_lt_div", out_r < e.b, 1);
                end
            end
        end
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_q", out_q, 0);
        check("rst_r", out_r, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        tick();
        rst = 1'b0;
        tick();

        // 13/3: busy cycles 1-4, done on cycle 5, then hold
        launch(4'd13, 4'd3);
        wait_done(SIZE);
        tick();
        check("done_pulse", done, 0);
        check("hold_q", out_q, 4);
        check("hold_r", out_r, 1);
        check("idle_busy", busy, 0);

        launch(4'd3, 4'd5);
        wait_done(SIZE);
        launch(4'd15, 4'd1);
        wait_done(SIZE);
        launch(4'd7, 4'd0);
        wait_done(0);
        tick();
        check("dbz_held", div_by_zero, 1);

        // start during RUN ignored, then back-to-back start in DONE
        launch(4'd13, 4'd3);
        tick();
        in_a  = 4'd9;
        in_b  = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(SIZE - 2);
        launch(4'd9, 4'd2);
        check("b2b_no_done", done, 0);
        check("b2b_busy", busy, 1);
        wait_done(SIZE);

        // Asynchronous reset mid-RUN
        launch(4'd13, 4'd3);
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_q", out_q, 0);
        check("arst_r", out_r, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dbz", div_by_zero, 0);
        void'(sb.pop_back());
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_done", done, 0);
        check("post_rst_busy", busy, 0);
        launch(4'd12, 4'd4);
        wait_done(SIZE);

        // Exhaustive sweep, back-to-back from DONE
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(SIZE'(a), SIZE'(b));
                wait_done((b == 0) ? 0 : SIZE);
            end
        end
        tick();
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider_n_bit.md
SEQ_DIVIDER_N_BIT -- requirements
Module: SEQ_DIVIDER_N_BIT

Interface
REQ-001 The block SHALL have parameter size, default 4: operand, quotient and remainder width in bits; legal for size >= 2.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-004 Port start SHALL be input, 1 bit: request to begin a division; sampled only in IDLE or DONE.
REQ-005 Port in_a SHALL be input, size bits: unsigned dividend, captured when start is accepted.
REQ-006 Port in_b SHALL be input, size bits: unsigned divisor, captured when start is accepted.
REQ-007 Port out_q SHALL be output, size bits: quotient, registered.
REQ-008 Port out_r SHALL be output, size bits: remainder, registered.
REQ-009 Port busy SHALL be output, 1 bit: high while a division is in progress.
REQ-010 Port done SHALL be output, 1 bit: single-cycle pulse marking valid out_q and out_r.
REQ-011 Port div_by_zero SHALL be output, 1 bit: high with done when the captured in_b was 0; held until the next accepted start.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE with start=1, the block SHALL capture in_a and in_b and load the bit counter with size. It SHALL then go to RUN, or to DONE if in_b==0.
REQ-014 In RUN, each cycle SHALL perform one restoring step, most-significant dividend bit first:
 - partial remainder, size+1 bits, shifted left with the next dividend bit appended;
 - trial subtract of the zero-extended divisor;
 - if no borrow: keep the difference and shift quotient bit 1 in;
 - otherwise: keep the shifted remainder and shift quotient bit 0 in.
REQ-015 RUN SHALL last exactly size cycles. On the final step the FSM SHALL go to DONE, and out_q and out_r SHALL be valid in the DONE cycle.
REQ-016 Latency SHALL be size+1 cycles from the accepting start edge to the done pulse; divide-by-zero latency SHALL be 1 cycle.
REQ-017 On divide-by-zero, out_q SHALL be all ones, out_r SHALL equal in_a, and div_by_zero SHALL be 1.
REQ-018 busy SHALL be 1 exactly while the state is RUN.
REQ-019 done SHALL be 1 exactly while the state is DONE, which SHALL last one cycle.
REQ-020 DONE SHALL go to IDLE if start=0, or accept a new operation if start=1, back-to-back with no bubble.
REQ-021 start while in RUN SHALL be ignored, with no effect on the operation in progress.
REQ-022 out_q and out_r SHALL hold their last result from DONE until the next accepted start; during RUN their values are unspecified.
REQ-023 Results SHALL satisfy in_a == out_q*in_b + out_r with out_r < in_b for every nonzero in_b.
REQ-024 in_a and in_b SHALL be ignored outside the accepting cycle; changing them during RUN SHALL not alter the result.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE and clear out_q, out_r, busy, done, div_by_zero, the counter and the partial remainder to 0, independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-027 The FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared, include-guarded constants header used by the ALU blocks.
REQ-028 The trial subtract SHALL be a combinational sub-module SUBTRACTOR_N_BIT (size+1 bits, outputs difference and borrow), instantiated once.

Verification
REQ-029 size=4, start with in_a=13, in_b=3 -> done on cycle 5 after start, out_q=4, out_r=1, div_by_zero=0, busy high for cycles 1-4.
REQ-030 in_a=3, in_b=5 -> out_q=0, out_r=3; in_a=15, in_b=1 -> out_q=15, out_r=0.
REQ-031 in_a=7, in_b=0 -> done one cycle after start with out_q=4'hF, out_r=7, div_by_zero=1.
REQ-032 start pulsed again with in_a=9, in_b=2 two cycles into a 13/3 run -> result remains q=4, r=1 with one done pulse; then start in the DONE cycle with 9/2 -> q=4, r=1 after 5 more cycles.
REQ-033 rst asserted asynchronously mid-RUN -> all outputs 0 at once with no done; the next start with 12/4 -> q=3, r=0.
REQ-034 Exhaustive sweep of all 256 operand pairs at size=4 checks REQ-023 and REQ-017 against a reference model.
